cpu_sequencer: RTL and testbench

//  Parametrised fetch/execute sequencer that drives the state input of the instruction decoder.

---
 rtl/cpu_sequencer_if.sv | 51 +++++
 rtl/cpu_sequencer.sv | 139 +++++++++++++
 tb/tb_cpu_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Sequencer bus: instruction fetch, decoder qualifiers and PC control.
// With SEQ_IRQ_EN defined the bus also carries irq, irq_ack and irq_vec.
interface cpu_sequencer_if #(
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned STATUS_W = 8,
  parameter int unsigned CNT_W    = 16
);
  logic [INSTR_W-1:0]  instruction;
  logic                instr_valid;
  logic [STATUS_W-1:0] status_reg;
  logic [3:0]          cond_field;
  logic                long_op;
  logic                branch_op;
  logic                stop_req;
  logic                resume;
  logic [1:0]          state;
  logic [INSTR_W-1:0]  instr_reg;
  logic                cond_pass;
  logic                pc_cnt_en;
  logic                pc_sload;
  logic                jump;
  logic                two_cycles_after_jump;
  logic [CNT_W-1:0]    retired_cnt;
`ifdef SEQ_IRQ_EN
  logic                irq;
  logic                irq_ack;
  logic [INSTR_W-1:0]  irq_vec;
`endif

  // Environment side: instruction RAM, decoder and PC.
  modport master (
    output instruction, instr_valid, status_reg, cond_field, long_op, branch_op,
           stop_req, resume,
    input  state, instr_reg, cond_pass, pc_cnt_en, pc_sload, jump,
           two_cycles_after_jump, retired_cnt
`ifdef SEQ_IRQ_EN
    , output irq, input irq_ack, irq_vec
`endif
  );

  // Sequencer side.
  modport slave (
    input  instruction, instr_valid, status_reg, cond_field, long_op, branch_op,
           stop_req, resume,
    output state, instr_reg, cond_pass, pc_cnt_en, pc_sload, jump,
           two_cycles_after_jump, retired_cnt
`ifdef SEQ_IRQ_EN
    , input irq, output irq_ack, irq_vec
`endif
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: FETCH/EXEC1/EXEC2/HALT machine, instruction
// register, registered condition result, PC qualifiers, post-jump shadow and
// retired-instruction counter.
// Optional feature macro: SEQ_IRQ_EN (adds a one-cycle IRQ entry state).
module cpu_sequencer #(
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned STATUS_W = 8,
  parameter int unsigned CNT_W    = 16
`ifdef SEQ_IRQ_EN
  , parameter int unsigned IE_BIT = 6,
  parameter logic [INSTR_W-1:0] IRQ_VEC = INSTR_W'(16'h0004)
`endif
) (
  input logic           clk,
  input logic           reset,
  cpu_sequencer_if.slave bus
);
  localparam int unsigned COND_IDX_N = 8;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC1 = 3'd1,
    S_EXEC2 = 3'd2,
    S_HALT  = 3'd3,
    S_IRQ   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q;
  logic               cond_q;
  logic               jump_q;
  logic               shadow_q;
  logic [CNT_W-1:0]   cnt_q;

  logic latch_c, retire_c, taken_c, irq_cyc_c, irq_entry_c, cnt_en_c, sload_c;
  logic cond_eval_c;
  logic [COND_IDX_N-1:0] st_ext, in_rng;

  // Condition indices beyond the status width always evaluate true.
  for (genvar i = 0; i < COND_IDX_N; i++) begin : g_st
    if (i < STATUS_W) begin : g_in
      assign st_ext[i] = bus.status_reg[i];
      assign in_rng[i] = 1'b1;
    end else begin : g_out
      assign st_ext[i] = 1'b1;
      assign in_rng[i] = 1'b0;
    end
  end

  // Condition evaluation; code x110 is unconditionally true.
  assign cond_eval_c = (bus.cond_field[2:0] == 3'b110)
                     | ~in_rng[bus.cond_field[2:0]]
                     | (st_ext[bus.cond_field[2:0]] ^ bus.cond_field[3]);

`ifdef SEQ_IRQ_EN
  // Interrupts are not taken inside the two-cycle post-jump shadow.
  assign irq_entry_c = bus.irq & bus.status_reg[IE_BIT] & ~jump_q & ~shadow_q;
  assign bus.irq_ack = irq_cyc_c;
  assign bus.irq_vec = IRQ_VEC;
`else
  assign irq_entry_c = 1'b0;
`endif

  // Next-state and cycle qualifiers.
  always_comb begin
    state_d   = state_q;
    latch_c   = 1'b0;
    retire_c  = 1'b0;
    taken_c   = 1'b0;
    irq_cyc_c = 1'b0;
    cnt_en_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (irq_entry_c) begin
          state_d = S_IRQ;
        end else if (bus.instr_valid) begin
          latch_c  = 1'b1;
          cnt_en_c = 1'b1;
          state_d  = S_EXEC1;
        end
      end
      S_EXEC1: begin
        if (bus.stop_req) begin
          state_d = S_HALT;
        end else if (bus.long_op) begin
          state_d = S_EXEC2;
        end else begin
          retire_c = 1'b1;
          taken_c  = bus.branch_op & cond_q;
          state_d  = S_FETCH;
        end
      end
      S_EXEC2: begin
        retire_c = 1'b1;
        taken_c  = bus.branch_op & cond_q;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        if (bus.resume) state_d = S_FETCH;
      end
      S_IRQ: begin
        irq_cyc_c = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State, instruction register, shadow and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      instr_q  <= '0;
      cond_q   <= 1'b0;
      jump_q   <= 1'b0;
      shadow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (latch_c) begin
        instr_q <= bus.instruction;
        cond_q  <= cond_eval_c;
      end
      jump_q   <= taken_c;
      shadow_q <= jump_q;
      if (retire_c & cond_q) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign sload_c                   = taken_c | irq_cyc_c;
  assign bus.pc_sload              = sload_c;
  assign bus.pc_cnt_en             = cnt_en_c & ~sload_c;
  assign bus.state                 = (state_q == S_IRQ) ? 2'b01 : state_q[1:0];
  assign bus.instr_reg             = instr_q;
  assign bus.cond_pass             = cond_q;
  assign bus.jump                  = jump_q;
  assign bus.two_cycles_after_jump = shadow_q;
  assign bus.retired_cnt           = cnt_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed and random instruction
// streams checked cycle by cycle against a transaction-level model.
module tb_cpu_sequencer;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned STATUS_W = 8;
  localparam int unsigned CNT_W    = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.INSTR_W(INSTR_W), .STATUS_W(STATUS_W), .CNT_W(CNT_W)) bus();

  cpu_sequencer #(.INSTR_W(INSTR_W), .STATUS_W(STATUS_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [CNT_W-1:0] exp_cnt;
  int since;  // cycles since the last taken branch

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_cond(input logic [3:0] c, input logic [STATUS_W-1:0] s);
    logic [7:0] ss;
    ss = 8'(s);
    if (c[2:0] == 3'b110) return 1'b1;
    return ss[c[2:0]] ^ c[3];
  endfunction

  // Check one cycle's outputs (inputs already driven), then advance to next negedge.
  task automatic cycle(input string tag, input logic [1:0] st, input bit cnt_en,
                       input bit sload, input bit retire_pass, input bit taken);
    #1;
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".pc_cnt_en"}, 32'(bus.pc_cnt_en), 32'(cnt_en));
    check({tag, ".pc_sload"}, 32'(bus.pc_sload), 32'(sload));
    check({tag, ".jump"}, 32'(bus.jump), 32'(since == 1));
    check({tag, ".two_after"}, 32'(bus.two_cycles_after_jump), 32'(since == 2));
    check({tag, ".retired"}, 32'(bus.retired_cnt), 32'(exp_cnt));
    if (retire_pass) exp_cnt = exp_cnt + CNT_W'(1);
    since = taken ? 1 : ((since < 100) ? since + 1 : 100);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.instruction = '0;
    bus.instr_valid = 1'b0;
    bus.status_reg  = '0;
    bus.cond_field  = '0;
    bus.long_op     = 1'b0;
    bus.branch_op   = 1'b0;
    bus.stop_req    = 1'b0;
    bus.resume      = 1'b0;
`ifdef SEQ_IRQ_EN
    bus.irq         = 1'b0;
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = '0;
    since = 100;
    #1;
    check("rst.instr_reg", 32'(bus.instr_reg), 32'h0);
    check("rst.cond_pass", 32'(bus.cond_pass), 32'h0);
    cycle("rst", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One instruction: wait states, fetch, exec (and optional halt).
  task automatic run_instr(input int waits, input logic [INSTR_W-1:0] word,
                           input logic [3:0] c, input logic [STATUS_W-1:0] s,
                           input bit lng, input bit br, input bit stp, input int halt_cycles);
    bit pass;
    pass = ref_cond(c, s);
    bus.status_reg = s;
    bus.cond_field = c;
    bus.long_op    = 1'b0;
    bus.branch_op  = 1'b0;
    bus.stop_req   = 1'b0;
    bus.resume     = 1'b0;
    for (int i = 0; i < waits; i++) begin
      bus.instr_valid = 1'b0;
      bus.instruction = INSTR_W'($urandom);
      cycle("wait", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    bus.instr_valid = 1'b1;
    bus.instruction = word;
    cycle("fetch", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.instr_valid = 1'($urandom);
    bus.instruction = INSTR_W'($urandom);
    bus.long_op     = lng;
    bus.branch_op   = br;
    bus.stop_req    = stp;
    #1;
    check("exec1.instr_reg", 32'(bus.instr_reg), 32'(word));
    check("exec1.cond_pass", 32'(bus.cond_pass), 32'(pass));
    if (stp) begin
      cycle("stop", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < halt_cycles; i++) begin
        bus.stop_req = 1'($urandom);
        cycle("halt", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      bus.resume = 1'b1;
      cycle("resume", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.resume = 1'b0;
    end else if (lng) begin
      cycle("exec1L", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("exec2", 2'b10, 1'b0, br & pass, pass, br & pass);
    end else begin
      cycle("exec1", 2'b01, 1'b0, br & pass, pass, br & pass);
    end
    bus.stop_req = 1'b0;
  endtask

`ifdef SEQ_IRQ_EN
  task automatic irq_test();
    bus.status_reg  = 8'h40;
    bus.irq         = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instruction = INSTR_W'($urandom);
    cycle("irq_entry", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("irq.ack", 32'(bus.irq_ack), 32'h1);
    check("irq.vec", 32'(bus.irq_vec), 32'h4);
    cycle("irq_cyc", 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.irq = 1'b0;
    run_instr(0, 16'h1234, 4'b0110, 8'h40, 1'b0, 1'b1, 1'b0, 0);
    bus.irq = 1'b1;
    bus.instr_valid = 1'b0;
    #1;
    check("blk1.ack", 32'(bus.irq_ack), 32'h0);
    cycle("blk1", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("blk2", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("late_entry", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("late.ack", 32'(bus.irq_ack), 32'h1);
    cycle("late_irq", 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.irq = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    do_reset();
    // Basic short op, wait states, long taken branch, false condition, halt.
    run_instr(0, 16'hA5A5, 4'b0110, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    run_instr(3, 16'h0F0F, 4'b0110, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    run_instr(0, 16'h1111, 4'b0110, 8'h00, 1'b1, 1'b1, 1'b0, 0);
    run_instr(0, 16'h2222, 4'b1000, 8'h01, 1'b0, 1'b1, 1'b0, 0);
    run_instr(0, 16'h3333, 4'b1110, 8'h00, 1'b0, 1'b1, 1'b0, 0);
    run_instr(1, 16'h4444, 4'b0000, 8'h01, 1'b0, 1'b0, 1'b1, 5);
    run_instr(0, 16'h5555, 4'b0111, 8'h80, 1'b1, 1'b0, 1'b0, 0);
`ifdef SEQ_IRQ_EN
    irq_test();
`endif
    // Reset during EXEC1 of a taken branch: no jump and counter cleared.
    bus.instr_valid = 1'b1;
    bus.cond_field  = 4'b0110;
    cycle("pre_rst_fetch", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.branch_op = 1'b1;
    do_reset();
    for (int n = 0; n < 200; n++) begin
      run_instr($urandom_range(0, 3), INSTR_W'($urandom), 4'($urandom),
                STATUS_W'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 5));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
